dotprod_seq: RTL and testbench

Sequencer that drives the shared ALU in MAC4 mode to compute an int8 dot product over two vectors in on-chip memory. Each 32-bit word holds four signed int8 lanes, and each MAC4 op returns the sum of the four lane products. The block streams `len` word pairs from two synchronous-read memories through the ALU and accumulates the per-word results into a 32-bit total. It sits between the core's control logic (start/done) and the ALU/memory read ports, as the inner-loop engine for TinyML dense and conv layers.

---
 rtl/tinyml_pkg.sv | 18 +
 rtl/dotprod_seq_if.sv | 33 +++
 rtl/dotprod_seq_acc.sv | 44 ++++
 rtl/dotprod_seq.sv | 113 +++++++++++
 tb/tb_dotprod_seq.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tinyml_pkg.sv
// Shared TinyML definitions: ALU opcodes and the dot-product sequencer state encoding.
package tinyml_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_MAC4 = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dp_state_t;

endpackage

// File: rtl/dotprod_seq_if.sv
// Bundle of the sequencer's control, operand-memory and shared-ALU signals.
interface dotprod_seq_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_rdata;
  logic [ADDR_W-1:0] b_addr;
  logic [31:0]       b_rdata;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [3:0]        alu_op;
  logic [31:0]       alu_result;
  logic              busy;
  logic              done;
  logic [31:0]       result;

  // Sequencer side
  modport master (
    input  start, base_a, base_b, len, a_rdata, b_rdata, alu_result,
    output a_addr, b_addr, alu_a, alu_b, alu_op, busy, done, result
  );

  // Core, memories and ALU side
  modport slave (
    output start, base_a, base_b, len, a_rdata, b_rdata, alu_result,
    input  a_addr, b_addr, alu_a, alu_b, alu_op, busy, done, result
  );
endinterface

// File: rtl/dotprod_seq_acc.sv
// 32-bit wrapping accumulator for the dot-product sequencer with the result register.
// Optional ReLU on the stored result when DOTPROD_RELU_EN is defined.
module dotprod_acc (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic signed [31:0] addend,
  input  logic               store,
  output logic signed [31:0] result
);

  logic signed [31:0] acc;
  logic signed [31:0] acc_nxt;

  function automatic logic signed [31:0] relu(input logic signed [31:0] v);
`ifdef DOTPROD_RELU_EN
    return v[31] ? 32'sd0 : v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    acc_nxt = acc;
    if (clr)
      acc_nxt = '0;
    else if (en)
      acc_nxt = acc + addend;
  end

  // The store edge also carries the last accumulate, so capture the next value
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      result <= '0;
    end else begin
      acc <= acc_nxt;
      if (store)
        result <= relu(acc_nxt);
    end
  end

endmodule

// File: rtl/dotprod_seq.sv
// Streams len int8x4 word pairs through the shared ALU in MAC4 mode and sums the results.
// Build option: DOTPROD_RELU_EN clamps a negative final result to zero.
module dotprod_seq
  import tinyml_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  dotprod_seq_if.master bus
);

  dp_state_t         state;
  logic [ADDR_W-1:0] base_a_r;
  logic [ADDR_W-1:0] base_b_r;
  logic [ADDR_W-1:0] a_addr_r;
  logic [ADDR_W-1:0] b_addr_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  idx_n;
  logic              vq;
  logic              busy_r;
  logic              done_r;
  logic [3:0]        alu_op_r;
  logic              accept;
  logic              acc_store;
  logic signed [31:0] result_s;

  assign idx_n     = idx + LEN_W'(1);
  assign accept    = (state == ST_IDLE) && bus.start;
  // Empty jobs go straight to DONE and must publish the freshly cleared total
  assign acc_store = (state == ST_DRAIN) || (accept && (bus.len == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      base_a_r <= '0;
      base_b_r <= '0;
      a_addr_r <= '0;
      b_addr_r <= '0;
      len_r    <= '0;
      idx      <= '0;
      vq       <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      alu_op_r <= OP_ADD;
    end else begin
      // An address presented in RUN returns data one cycle later
      vq <= (state == ST_RUN);
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            base_a_r <= bus.base_a;
            base_b_r <= bus.base_b;
            len_r    <= bus.len;
            idx      <= '0;
            a_addr_r <= bus.base_a;
            b_addr_r <= bus.base_b;
            if (bus.len == '0) begin
              state  <= ST_DONE;
              done_r <= 1'b1;
            end else begin
              state    <= ST_RUN;
              busy_r   <= 1'b1;
              alu_op_r <= OP_MAC4;
            end
          end
        end
        ST_RUN: begin
          if (idx == len_r - LEN_W'(1)) begin
            state <= ST_DRAIN;
          end else begin
            idx      <= idx_n;
            a_addr_r <= base_a_r + ADDR_W'(idx_n);
            b_addr_r <= base_b_r + ADDR_W'(idx_n);
          end
        end
        ST_DRAIN: begin
          state    <= ST_DONE;
          busy_r   <= 1'b0;
          done_r   <= 1'b1;
          alu_op_r <= OP_ADD;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_r <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dotprod_acc u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (vq),
    .addend ($signed(bus.alu_result)),
    .store  (acc_store),
    .result (result_s)
  );

  assign bus.a_addr = a_addr_r;
  assign bus.b_addr = b_addr_r;
  assign bus.alu_a  = bus.a_rdata;
  assign bus.alu_b  = bus.b_rdata;
  assign bus.alu_op = alu_op_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_s;

endmodule

// File: tb/tb_dotprod_seq.sv
// Self-checking bench for dotprod_seq: vector table, hand sequences and random jobs vs a dot-product model.
module tb_dotprod_seq;
  import tinyml_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dotprod_seq_if #(.ADDR_W(8), .LEN_W(8)) io ();

  dotprod_seq #(.ADDR_W(8), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (io)
  );

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  // Synchronous-read operand memories
  always @(posedge clk) begin
    io.a_rdata <= mem_a[io.a_addr];
    io.b_rdata <= mem_b[io.b_addr];
  end

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int s;
    s = 0;
    case (op)
      OP_MAC4: begin
        for (int l = 0; l < 4; l++) begin
          logic signed [7:0] x, y;
          x = a[8*l +: 8];
          y = b[8*l +: 8];
          s += int'(x) * int'(y);
        end
        return s;
      end
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return a + b;
    endcase
  endfunction

  assign io.alu_result = alu_f(io.alu_op, io.alu_a, io.alu_b);

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] prev_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", name, act, $signed(act), exp, $signed(exp));
  endtask

  function automatic logic [31:0] exp_relu(input logic signed [31:0] v);
`ifdef DOTPROD_RELU_EN
    return (v < 0) ? 32'd0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: plain sum over word pairs of signed byte products, addresses wrapping mod 256
  function automatic logic [31:0] ref_dot(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] ln);
    int s;
    logic [7:0] ia, ib;
    logic [31:0] wa, wb;
    s = 0;
    for (int k = 0; k < int'(ln); k++) begin
      ia = ba + 8'(k);
      ib = bb + 8'(k);
      wa = mem_a[ia];
      wb = mem_b[ib];
      for (int l = 0; l < 4; l++) begin
        logic signed [7:0] x, y;
        x = wa[8*l +: 8];
        y = wb[8*l +: 8];
        s = s + int'(x) * int'(y);
      end
    end
    return s;
  endfunction

  task automatic run_job(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] ln,
                         input logic [31:0] exp, input string tag);
    int lat, busy_cnt, addr_bad, op_bad, hold_bad, exp_lat;
    bit seen;
    logic [7:0] ea, eb;
    lat = 0; busy_cnt = 0; addr_bad = 0; op_bad = 0; hold_bad = 0; seen = 0;
    exp_lat = (ln == 0) ? 1 : int'(ln) + 2;
    @(negedge clk);
    io.start = 1'b1; io.base_a = ba; io.base_b = bb; io.len = ln;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    io.base_a = 8'($urandom); io.base_b = 8'($urandom); io.len = 8'($urandom);
    for (int c = 1; c <= int'(ln) + 6 && !seen; c++) begin
      @(negedge clk);
      if (io.busy) begin
        busy_cnt++;
        if (io.alu_op !== OP_MAC4) op_bad++;
      end
      if (c <= int'(ln)) begin
        ea = ba + 8'(c - 1);
        eb = bb + 8'(c - 1);
        if (io.a_addr !== ea || io.b_addr !== eb) addr_bad++;
      end
      if (io.done) begin
        seen = 1;
        lat = c;
      end else if (io.result !== prev_res) begin
        hold_bad++;
      end
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".busy_cycles"}, busy_cnt, (ln == 0) ? 0 : int'(ln) + 1);
    check({tag, ".addr_seq_errors"}, addr_bad, 0);
    check({tag, ".op_errors"}, op_bad, 0);
    check({tag, ".result_hold_errors"}, hold_bad, 0);
    check({tag, ".result"}, io.result, exp);
    check({tag, ".op_at_done"}, io.alu_op, OP_ADD);
    prev_res = exp;
  endtask

  typedef struct {
    logic [7:0]         ba;
    logic [7:0]         bb;
    logic [7:0]         ln;
    logic [31:0]        wa;
    logic [31:0]        wb;
    logic signed [31:0] raw;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt, bcnt;
    logic [31:0] rseen, exp;
    logic [7:0] ba, bb, ln;

    tbl[0] = '{8'h20, 8'h40, 8'd1, 32'h01020304, 32'h01010101, 32'sd10};
    tbl[1] = '{8'h20, 8'h40, 8'd4, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'sd258064};
    tbl[2] = '{8'h20, 8'h40, 8'd2, 32'h80808080, 32'h7F7F7F7F, -32'sd130048};
    tbl[3] = '{8'h20, 8'h40, 8'd0, 32'h12345678, 32'h11111111, 32'sd0};
    tbl[4] = '{8'h30, 8'h50, 8'd3, 32'hFFFFFFFF, 32'h01010101, -32'sd12};
    tbl[5] = '{8'hFC, 8'hA0, 8'd5, 32'h01FF7F80, 32'h02020202, -32'sd10};

    for (int i = 0; i < 256; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end

    rst = 1'b1;
    io.start = 1'b0; io.base_a = '0; io.base_b = '0; io.len = '0;
    prev_res = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.busy", io.busy, 0);
    check("reset.done", io.done, 0);
    check("reset.result", io.result, 0);
    check("reset.alu_op", io.alu_op, OP_ADD);
    check("reset.a_addr", io.a_addr, 0);
    check("reset.b_addr", io.b_addr, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < int'(tbl[i].ln); k++) begin
        mem_a[8'(tbl[i].ba + 8'(k))] = tbl[i].wa;
        mem_b[8'(tbl[i].bb + 8'(k))] = tbl[i].wb;
      end
      run_job(tbl[i].ba, tbl[i].bb, tbl[i].ln, exp_relu(tbl[i].raw), $sformatf("vec%0d", i));
    end

    // Address wrap on A, linear on B
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
    run_job(8'hFE, 8'h10, 8'd4, exp_relu(ref_dot(8'hFE, 8'h10, 8'd4)), "wrap");

    // start during RUN must be dropped, not queued
    exp = exp_relu(ref_dot(8'h10, 8'h90, 8'd3));
    @(negedge clk);
    io.start = 1'b1; io.base_a = 8'h10; io.base_b = 8'h90; io.len = 8'd3;
    @(posedge clk);
    #1;
    io.start = 1'b0; io.base_a = 8'h77; io.len = 8'd1;
    @(negedge clk);
    io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    dcnt = 0; bcnt = 0; rseen = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (io.done) begin
        dcnt++;
        rseen = io.result;
      end
      if (io.busy) bcnt++;
    end
    check("ignored_start.done_count", dcnt, 1);
    check("ignored_start.result", rseen, exp);
    check("ignored_start.busy_after", io.busy, 0);
    check("ignored_start.busy_cycles", bcnt, 2);
    prev_res = exp;

    // Reset two cycles into an 8-word job
    @(negedge clk);
    io.start = 1'b1; io.base_a = 8'h00; io.base_b = 8'h80; io.len = 8'd8;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset.busy", io.busy, 0);
    check("midreset.done", io.done, 0);
    check("midreset.result", io.result, 0);
    check("midreset.alu_op", io.alu_op, OP_ADD);
    check("midreset.a_addr", io.a_addr, 0);
    rst = 1'b0;
    prev_res = '0;
    run_job(8'h05, 8'h06, 8'd1, exp_relu(ref_dot(8'h05, 8'h06, 8'd1)), "post_reset");

    // Random back-to-back jobs against the model
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] = $urandom;
        mem_b[i] = $urandom;
      end
      ba = 8'($urandom);
      bb = 8'($urandom);
      ln = 8'($urandom_range(0, 24));
      run_job(ba, bb, ln, exp_relu(ref_dot(ba, bb, ln)), $sformatf("rand%0d", j));
    end

    @(negedge clk);
    check("final.done_low", io.done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
